// File: rtl/d_ffec32.sv
// d_ffec32: WIDTH-bit edge-triggered register with load enable and
// asynchronous active-high clear. Q/Qn are complementary outputs.
// Built from WIDTH independent D_FFEC bit cells that share Clk/En/Clrn.

// d_ffec: single-bit D flip-flop with enable and asynchronous clear.
module d_ffec (
  input  logic clk,
  input  logic clrn,
  input  logic en,
  input  logic d,
  output logic q,
  output logic qn
);

  logic d_mux;

  // Enable mux: recirculate the stored bit when not loading.
  always_comb begin
    d_mux = en ? d : q;
  end

  // Storage bit; clear acts immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      q <= 1'b0;
    end else begin
      q <= d_mux;
    end
  end

  // Complement is derived from q, never stored, so the two cannot disagree.
  assign qn = ~q;

endmodule

module d_ffec32 #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             En,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  // One bit cell per data bit; bits never interact.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ffec u_cell (
      .clk  (Clk),
      .clrn (Clrn),
      .en   (En),
      .d    (D[i]),
      .q    (Q[i]),
      .qn   (Qn[i])
    );
  end

endmodule

// File: tb/tb_d_ffec32.sv
// tb_d_ffec32: scoreboard bench for d_ffec32. Stimulus steps push the
// expected Q into a queue; a monitor samples Q/Qn on each falling edge and
// pops the matching expectation.
module tb_d_ffec32;

  logic        Clk;
  logic        Clrn;
  logic        En;
  logic [31:0] D;
  logic [31:0] Q;
  logic [31:0] Qn;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] q;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur;     // reference register value after the most recent edge
  bit          cur_known;

  d_ffec32 #(.WIDTH(32)) dut (
    .Clk  (Clk),
    .Clrn (Clrn),
    .En   (En),
    .D    (D),
    .Q    (Q),
    .Qn   (Qn)
  );

  initial begin
    Clk = 1'b0;
    forever #20 Clk = ~Clk;
  end

  // Monitor: sample between rising edges and compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (Q !== e.q) begin
          bad++;
          $display("FAIL %s: Q=%08h expected %08h", e.tag, Q, e.q);
        end
        total++;
        if (Qn !== ~e.q) begin
          bad++;
          $display("FAIL %s_qn: Qn=%08h expected %08h", e.tag, Qn, ~e.q);
        end
      end
    end
  end

  // One cycle of stimulus: inputs change 5 ns after a rising edge, the
  // monitor samples 15 ns later (still before the next rising edge).
  // Expectation at that sample: zero if clear is now asserted (async),
  // otherwise the value loaded at the preceding edge.
  task automatic step(input logic [31:0] d, input logic en, input logic clr,
                      input string tag, input int glitches = 0);
    exp_t e;
    @(posedge Clk);
    #5;
    Clrn = clr;
    En   = en;
    for (int g = 0; g < glitches; g++) begin
      D = $urandom;
      #3;
    end
    D = d;
    e.q   = clr ? 32'h0 : cur;
    e.tag = tag;
    if (clr || cur_known) sb.push_back(e);
    // value the register holds after the coming rising edge
    if (clr) begin
      cur = 32'h0;
      cur_known = 1'b1;
    end else if (en) begin
      cur = d;
      cur_known = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        ren;
    logic        rclr;
    int          guard;

    cur = 32'h0;
    cur_known = 1'b0;
    Clrn = 1'b1;
    En   = 1'b0;
    D    = 32'h0;

    // Reset state
    step(32'hDEADBEEF, 1'b1, 1'b1, "reset");
    step(32'hDEADBEEF, 1'b1, 1'b1, "reset_hold");

    // Load sequence after clear release
    step(32'h0F0F0F0F, 1'b1, 1'b0, "rel");
    step(32'hF0F0F0F0, 1'b1, 1'b0, "load0");
    step(32'h33333333, 1'b1, 1'b0, "load1");
    step(32'hCCCCCCCC, 1'b1, 1'b0, "load2");
    step(32'hCCCCCCCC, 1'b1, 1'b0, "load3");

    // Async clear mid-cycle after loading all ones
    step(32'hFFFFFFFF, 1'b1, 1'b0, "ones0");
    step(32'hFFFFFFFF, 1'b1, 1'b0, "ones1");
    step(32'hFFFFFFFF, 1'b1, 1'b0, "ones2");
    step(32'hFFFFFFFF, 1'b1, 1'b1, "aclr0");
    step(32'hFFFFFFFF, 1'b1, 1'b1, "aclr1");
    step(32'hFFFFFFFF, 1'b1, 1'b1, "aclr2");

    // Enable hold
    step(32'hA5A5A5A5, 1'b1, 1'b0, "relh");
    step(32'h5A5A5A5A, 1'b0, 1'b0, "hold0");
    step(32'h5A5A5A5A, 1'b0, 1'b0, "hold1");
    step(32'h5A5A5A5A, 1'b0, 1'b0, "hold2");
    step(32'h5A5A5A5A, 1'b1, 1'b0, "hold3");
    step(32'h00000000, 1'b0, 1'b0, "hold_ld");

    // Mid-cycle D glitches: only the value present at the edge loads
    step(32'h13579BDF, 1'b1, 1'b0, "gl0", 4);
    step(32'h2468ACE0, 1'b1, 1'b0, "gl1", 4);
    step(32'h0000FFFF, 1'b1, 1'b0, "gl2", 4);
    step(32'h0000FFFF, 1'b0, 1'b0, "gl3", 4);

    // Clear spanning a rising edge, then an enabled load
    step(32'h12345678, 1'b1, 1'b1, "clre0");
    step(32'h12345678, 1'b1, 1'b0, "clre1");
    step(32'h12345678, 1'b1, 1'b0, "clre2");

    // Randomized traffic
    for (int i = 0; i < 1000; i++) begin
      rd   = $urandom;
      ren  = 1'($urandom_range(0, 1));
      rclr = ($urandom_range(0, 15) == 0);
      step(rd, ren, rclr, "rand", int'($urandom_range(0, 2)));
    end
    step(32'h0, 1'b0, 1'b0, "tail");

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(posedge Clk);
      guard++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
